// File: rtl/datamem_stage_pkg.sv
// Shared definitions for the memory-access stage.
// Load/store encodings, MMIO addresses, RAM geometry and store lane helpers.
package datamem_stage_pkg;

  localparam int unsigned DMEM_AW = 14;
  localparam int unsigned XLEN    = 32;

  localparam logic [31:0] UART_ADDR = 32'hF6FF_F070;
  localparam logic [31:0] HC_ADDR   = 32'hFFFF_FF00;

  typedef enum logic [2:0] {
    NOTLOAD = 3'd0,
    LB      = 3'd1,
    LH      = 3'd2,
    LW      = 3'd3,
    LBU     = 3'd4,
    LHU     = 3'd5
  } load_e;

  typedef enum logic [1:0] {
    NOTSTORE = 2'd0,
    SB       = 2'd1,
    SH       = 2'd2,
    SW       = 2'd3
  } store_e;

  // Byte-lane enables for a store at byte offset off.
  function automatic logic [3:0] store_be(input store_e op, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (op)
      SB:      be = 4'(4'b0001 << off);
      SH:      be = off[1] ? 4'b1100 : 4'b0011;
      SW:      be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Store data with the low byte/half replicated across all lanes.
  function automatic logic [31:0] store_data(input store_e op, input logic [31:0] rs2);
    logic [31:0] d;
    case (op)
      SB:      d = {4{rs2[7:0]}};
      SH:      d = {2{rs2[15:0]}};
      default: d = rs2;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/datamem_stage_dmem_ram.sv
// Data RAM: 2**AW x 32-bit words, byte write enables, async read, sync write.
module dmem_ram #(
  parameter int unsigned AW = 14
) (
  input  logic          clk,
  input  logic [AW-1:0] i_addr,
  input  logic [3:0]    i_we,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata_c
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [31:0] r_mem [DEPTH];

  assign o_rdata_c = r_mem[i_addr];

  // Byte-masked write at the clock edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/datamem_stage.sv
// Memory-access stage of the RV32I core: loads/stores on the data RAM,
// hardware-counter MMIO on the load path, and writeback field registers.
// Optional feature macro: HC_MMIO_EN (loads of HC_ADDR return hc_OUT_data).
module datamem_stage
  import datamem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  info_load,
  input  logic [1:0]  info_store,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2,
  input  logic        write_reg,
  input  logic [4:0]  dst_addr,
  input  logic [31:0] next_pc,
  input  logic [31:0] hc_OUT_data,
  output logic [31:0] next_pcD,
  output logic        w_reg,
  output logic [31:0] rd_data,
  output logic [31:0] branchD,
  output logic [4:0]  dst_addrD
);

  logic [DMEM_AW-1:0] w_index;
  logic [1:0]         w_off;
  logic               w_is_uart;
  logic               w_is_hc;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata;
  logic [31:0]        w_ram_rdata;
  logic [31:0]        w_src;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic               w_is_load;
  logic [31:0]        w_rd_next;

  logic [31:0] r_next_pc;
  logic        r_w_reg;
  logic [31:0] r_rd_data;
  logic [4:0]  r_dst_addr;

  assign w_index   = alu_result[DMEM_AW+1:2];
  assign w_off     = alu_result[1:0];
  assign w_is_uart = (alu_result == UART_ADDR);
  assign w_is_hc   = (alu_result == HC_ADDR);

  // MMIO stores and stores under reset never reach the RAM.
  assign w_be    = store_be(store_e'(info_store), w_off)
                 & {4{reset & ~w_is_uart & ~w_is_hc}};
  assign w_wdata = store_data(store_e'(info_store), rs2);

  dmem_ram #(.AW(DMEM_AW)) u_ram (
    .clk       (clk),
    .i_addr    (w_index),
    .i_we      (w_be),
    .i_wdata   (w_wdata),
    .o_rdata_c (w_ram_rdata)
  );

`ifdef HC_MMIO_EN
  assign w_src = w_is_hc ? hc_OUT_data : w_ram_rdata;
`else
  logic w_unused_hc;
  assign w_unused_hc = ^hc_OUT_data;
  assign w_src = w_ram_rdata;
`endif

  // Lane steering, extension and writeback data selection.
  always_comb begin
    w_byte    = 8'h00;
    w_half    = w_off[1] ? w_src[31:16] : w_src[15:0];
    w_is_load = 1'b0;
    w_rd_next = alu_result;
    case (w_off)
      2'd0:    w_byte = w_src[7:0];
      2'd1:    w_byte = w_src[15:8];
      2'd2:    w_byte = w_src[23:16];
      default: w_byte = w_src[31:24];
    endcase
    case (load_e'(info_load))
      LB:  begin w_is_load = 1'b1; w_rd_next = {{24{w_byte[7]}}, w_byte}; end
      LBU: begin w_is_load = 1'b1; w_rd_next = {24'h0, w_byte}; end
      LH:  begin w_is_load = 1'b1; w_rd_next = {{16{w_half[15]}}, w_half}; end
      LHU: begin w_is_load = 1'b1; w_rd_next = {16'h0, w_half}; end
      LW:  begin w_is_load = 1'b1; w_rd_next = w_src; end
      default: w_rd_next = alu_result;
    endcase
    if (w_is_load && w_is_uart) w_rd_next = 32'h0;
  end

  // Writeback field registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_next_pc  <= '0;
      r_w_reg    <= 1'b0;
      r_rd_data  <= '0;
      r_dst_addr <= '0;
    end else begin
      r_next_pc  <= next_pc;
      r_w_reg    <= write_reg & (dst_addr != 5'd0);
      r_rd_data  <= w_rd_next;
      r_dst_addr <= dst_addr;
    end
  end

  assign next_pcD  = r_next_pc;
  assign w_reg     = r_w_reg;
  assign rd_data   = r_rd_data;
  assign dst_addrD = r_dst_addr;
  assign branchD   = 32'h0;

endmodule

// File: tb/tb_datamem_stage.sv
// Bench for datamem_stage: directed vector table plus a model-driven random phase.
module tb_datamem_stage;

  localparam logic [31:0] UART_A = 32'hF6FF_F070;
  localparam logic [31:0] HC_A   = 32'hFFFF_FF00;
  localparam logic [31:0] HC_VAL = 32'hCAFE_0001;

  typedef struct {
    logic        rst;
    logic [2:0]  ld;
    logic [1:0]  st;
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
    logic [4:0]  dst;
    logic [31:0] npc;
    logic [31:0] e_rd;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        w;
    logic [4:0]  dst;
    logic [31:0] npc;
    int          idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  info_load = 3'd0;
  logic [1:0]  info_store = 2'd0;
  logic [31:0] alu_result = 32'h0;
  logic [31:0] rs2 = 32'h0;
  logic        write_reg = 1'b0;
  logic [4:0]  dst_addr = 5'd0;
  logic [31:0] next_pc = 32'h0;
  logic [31:0] hc_OUT_data = HC_VAL;
  logic [31:0] next_pcD;
  logic        w_reg;
  logic [31:0] rd_data;
  logic [31:0] branchD;
  logic [4:0]  dst_addrD;

  int   checks = 0;
  int   failures = 0;
  vec_t tbl[$];
  exp_t exp_q[$];
  logic [31:0] model [16];

  always #5 clk = ~clk;

  datamem_stage dut (
    .clk(clk), .reset(reset), .info_load(info_load), .info_store(info_store),
    .alu_result(alu_result), .rs2(rs2), .write_reg(write_reg), .dst_addr(dst_addr),
    .next_pc(next_pc), .hc_OUT_data(hc_OUT_data), .next_pcD(next_pcD), .w_reg(w_reg),
    .rd_data(rd_data), .branchD(branchD), .dst_addrD(dst_addrD)
  );

  task automatic add(input logic rst, input logic [2:0] ld, input logic [1:0] st,
                     input logic [31:0] addr, input logic [31:0] data, input logic wr,
                     input logic [4:0] dst, input logic [31:0] npc, input logic [31:0] e_rd);
    vec_t v;
    v.rst = rst; v.ld = ld; v.st = st; v.addr = addr; v.data = data;
    v.wr = wr; v.dst = dst; v.npc = npc; v.e_rd = e_rd;
    tbl.push_back(v);
  endtask

  task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%08h required=%08h", name, idx, act, req);
    end
  endtask

  // Drive one instruction, queue its expectation, compare after the edge.
  task automatic step(input vec_t v, input int idx);
    exp_t e;
    exp_t g;
    @(negedge clk);
    reset = v.rst; info_load = v.ld; info_store = v.st; alu_result = v.addr;
    rs2 = v.data; write_reg = v.wr; dst_addr = v.dst; next_pc = v.npc;
    e.rd  = v.rst ? v.e_rd : 32'h0;
    e.w   = v.rst & v.wr & (v.dst != 5'd0);
    e.dst = v.rst ? v.dst : 5'd0;
    e.npc = v.rst ? v.npc : 32'h0;
    e.idx = idx;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty vec=%0d actual=0 required=1", idx);
    end else begin
      g = exp_q.pop_front();
      cmp("rd_data", g.idx, rd_data, g.rd);
      cmp("w_reg", g.idx, 32'(w_reg), 32'(g.w));
      cmp("dst_addrD", g.idx, 32'(dst_addrD), 32'(g.dst));
      cmp("next_pcD", g.idx, next_pcD, g.npc);
      cmp("branchD", g.idx, branchD, 32'h0);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] ld, input logic [31:0] w,
                                             input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * int'(off)));
    h = off[1] ? w[31:16] : w[15:0];
    case (ld)
      3'd1: return {{24{b[7]}}, b};
      3'd2: return {{16{h[15]}}, h};
      3'd3: return w;
      3'd4: return {24'h0, b};
      3'd5: return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [1:0] st, input logic [31:0] w,
                                              input logic [31:0] d, input logic [1:0] off);
    logic [31:0] r;
    r = w;
    case (st)
      2'd1: r[8*int'(off) +: 8] = d[7:0];
      2'd2: if (off[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
      2'd3: r = d;
      default: r = w;
    endcase
    return r;
  endfunction

  logic [31:0] hc_w, hc_b, hc_h;

  initial begin
`ifdef HC_MMIO_EN
    hc_w = HC_VAL; hc_b = 32'h0000_0001; hc_h = 32'h0000_0001;
`else
    hc_w = 32'h3131_3131; hc_b = 32'h0000_0031; hc_h = 32'h0000_3131;
`endif
    // Reset and store suppression under reset
    add(0, 0, 0, 32'h0000_0000, 32'h0,         1, 5'd7, 32'h0000_0004, 32'h0);
    add(1, 0, 3, 32'h0000_0400, 32'h1122_3344, 0, 5'd0, 32'h0000_0004, 32'h0000_0400);
    add(0, 0, 3, 32'h0000_0400, 32'hDEAD_BEEF, 1, 5'd3, 32'h0000_0008, 32'h0);
    add(1, 3, 0, 32'h0000_0400, 32'h0,         1, 5'd3, 32'h0000_000C, 32'h1122_3344);
    // Width and extension on 0x8000_00FF
    add(1, 0, 3, 32'h0000_0100, 32'h8000_00FF, 0, 5'd0, 32'h0000_0010, 32'h0000_0100);
    add(1, 1, 0, 32'h0000_0100, 32'h0,         1, 5'd1, 32'h0000_0014, 32'hFFFF_FFFF);
    add(1, 4, 0, 32'h0000_0100, 32'h0,         1, 5'd2, 32'h0000_0018, 32'h0000_00FF);
    add(1, 1, 0, 32'h0000_0101, 32'h0,         1, 5'd3, 32'h0000_001C, 32'h0000_0000);
    add(1, 4, 0, 32'h0000_0103, 32'h0,         1, 5'd4, 32'h0000_0020, 32'h0000_0080);
    add(1, 1, 0, 32'h0000_0103, 32'h0,         1, 5'd5, 32'h0000_0024, 32'hFFFF_FF80);
    add(1, 2, 0, 32'h0000_0100, 32'h0,         1, 5'd6, 32'h0000_0028, 32'h0000_00FF);
    add(1, 2, 0, 32'h0000_0102, 32'h0,         1, 5'd7, 32'h0000_002C, 32'hFFFF_8000);
    add(1, 5, 0, 32'h0000_0102, 32'h0,         1, 5'd8, 32'h0000_0030, 32'h0000_8000);
    add(1, 2, 0, 32'h0000_0103, 32'h0,         1, 5'd9, 32'h0000_0034, 32'hFFFF_8000);
    add(1, 3, 0, 32'h0000_0100, 32'h0,         1, 5'd10, 32'h0000_0038, 32'h8000_00FF);
    add(1, 3, 0, 32'h0000_0103, 32'h0,         1, 5'd11, 32'h0000_003C, 32'h8000_00FF);
    // Partial stores with replication
    add(1, 0, 3, 32'h0000_0204, 32'h0,         0, 5'd0, 32'h0000_0040, 32'h0000_0204);
    add(1, 0, 1, 32'h0000_0205, 32'hFFFF_FF12, 0, 5'd0, 32'h0000_0044, 32'h0000_0205);
    add(1, 3, 0, 32'h0000_0204, 32'h0,         1, 5'd12, 32'h0000_0048, 32'h0000_1200);
    add(1, 0, 2, 32'h0000_0206, 32'h1234_BEEF, 0, 5'd0, 32'h0000_004C, 32'h0000_0206);
    add(1, 3, 0, 32'h0000_0204, 32'h0,         1, 5'd13, 32'h0000_0050, 32'hBEEF_1200);
    // Non-load ALU passthrough, x0 suppression, invalid load code
    add(1, 0, 0, 32'h0000_1234, 32'h0,         1, 5'd5, 32'h0000_0040, 32'h0000_1234);
    add(1, 0, 0, 32'h0000_1234, 32'h0,         1, 5'd0, 32'h0000_0040, 32'h0000_1234);
    add(1, 6, 0, 32'h0000_0100, 32'h0,         1, 5'd14, 32'h0000_0054, 32'h0000_0100);
    add(1, 7, 0, 32'h0000_0101, 32'h0,         1, 5'd15, 32'h0000_0058, 32'h0000_0101);
    // Index wrap through ignored upper address bits
    add(1, 0, 3, 32'h0001_0100, 32'h5A5A_5A5A, 0, 5'd0, 32'h0000_005C, 32'h0001_0100);
    add(1, 3, 0, 32'h0000_0100, 32'h0,         1, 5'd16, 32'h0000_0060, 32'h5A5A_5A5A);
    // UART MMIO: reads 0, store leaves aliased word alone
    add(1, 0, 3, 32'h0000_F070, 32'h7777_7777, 0, 5'd0, 32'h0000_0064, 32'h0000_F070);
    add(1, 0, 3, UART_A,        32'h9999_9999, 0, 5'd0, 32'h0000_0068, UART_A);
    add(1, 3, 0, UART_A,        32'h0,         1, 5'd17, 32'h0000_006C, 32'h0);
    add(1, 3, 0, 32'h0000_F070, 32'h0,         1, 5'd18, 32'h0000_0070, 32'h7777_7777);
    // Hardware counter MMIO
    add(1, 0, 3, 32'h0000_FF00, 32'h3131_3131, 0, 5'd0, 32'h0000_0074, 32'h0000_FF00);
    add(1, 0, 3, HC_A,          32'h4242_4242, 0, 5'd0, 32'h0000_0078, HC_A);
    add(1, 3, 0, HC_A,          32'h0,         1, 5'd19, 32'h0000_007C, hc_w);
    add(1, 1, 0, HC_A,          32'h0,         1, 5'd20, 32'h0000_0080, hc_b);
    add(1, 2, 0, HC_A,          32'h0,         1, 5'd21, 32'h0000_0084, hc_h);
    add(1, 3, 0, 32'h0000_FF00, 32'h0,         1, 5'd22, 32'h0000_0088, 32'h3131_3131);

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // Random load/store mix against a word model on 16 words at 0x300
    for (int i = 0; i < 16; i++) begin
      vec_t v;
      model[i] = $urandom;
      v.rst = 1; v.ld = 0; v.st = 3; v.addr = 32'h300 + 32'(4 * i); v.data = model[i];
      v.wr = 0; v.dst = 0; v.npc = $urandom; v.e_rd = v.addr;
      step(v, 1000 + i);
    end
    for (int i = 0; i < 120; i++) begin
      vec_t v;
      int   k;
      int   wi;
      k  = $urandom_range(0, 8);
      wi = $urandom_range(0, 15);
      v.rst = 1'b1; v.ld = 3'd0; v.st = 2'd0;
      v.addr = 32'h300 + 32'(4 * wi) + 32'($urandom_range(0, 3));
      v.data = $urandom; v.wr = 1'($urandom); v.dst = 5'($urandom); v.npc = $urandom;
      v.e_rd = v.addr;
      if (k >= 1 && k <= 5) begin
        v.ld = 3'(k);
        v.e_rd = model_load(v.ld, model[wi], v.addr[1:0]);
      end else if (k >= 6) begin
        v.st = 2'(k - 5);
        model[wi] = model_store(v.st, model[wi], v.data, v.addr[1:0]);
      end
      step(v, 2000 + i);
    end

    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
